door_detector: RTL and testbench
================================

DOOR_DETECTOR -- requirements
Module: door_detector

Interface
REQ-001 Parameter DOOR_MARGIN, default 8: edge-band depth in pixels for door hit detection.
REQ-002 Parameter DOOR_LO, default 200: lower bound, inclusive, of the door span along the edge, for both axes.
REQ-003 Parameter DOOR_HI, default 280: upper bound, inclusive, of the door span along the edge, for both axes.
REQ-004 Parameter COOLDOWN_FRAMES, default 8: minimum frames after a door event before re-arming; legal range 1..255.
REQ-005 Clk  input  1  system clock; all state on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 vsync  input  1  raw VGA vertical sync, asynchronous to Clk.
REQ-008 player_x  input  10  player position x, 0..639, unsigned.
REQ-009 player_y  input  10  player position y, 0..479, unsigned.
REQ-010 room  input  3  current room index, 0..7.
REQ-011 doorcode  output  3  0 = none, 1 = left, 2 = right, 3 = top, 4 = bottom; 5..7 never driven.
REQ-012 busy  output  1  high in every state except ARMED.

Function
REQ-013 vsync SHALL pass through a 2-flop synchronizer; frame_tick is a 1-Clk pulse on each synchronized rising edge.
REQ-014 Left hit: player_x <= DOOR_MARGIN and DOOR_LO <= player_y <= DOOR_HI.
REQ-015 Right hit: player_x >= 639-DOOR_MARGIN, same y span.
REQ-016 Top hit: player_y <= DOOR_MARGIN and DOOR_LO <= player_x <= DOOR_HI.
REQ-017 Bottom hit: player_y >= 479-DOOR_MARGIN, same x span.
REQ-018 Each hit is qualified by the door mask for the current room.
- room 0: R, T
- room 1: L, R
- room 2: B
- room 3: L, B
- room 4: T, R
- room 5: L, R, T
- room 6: B
- room 7: L
REQ-019 If several qualified hits occur in the same frame, priority SHALL be left > right > top > bottom.
REQ-020 States: ARMED, ASSERT, COOLDOWN.
REQ-021 ARMED:
- doorcode = 0.
- On frame_tick with a qualified hit: latch the code and move to ASSERT on the next Clk.
- Hits without frame_tick are ignored.
REQ-022 ASSERT:
- doorcode = latched code, stable for the whole state.
- Stay until the next frame_tick, so that one full raw vsync rising edge falls inside the assertion.
- On that tick: go to COOLDOWN, load cooldown counter with COOLDOWN_FRAMES, doorcode = 0 from the next Clk.
REQ-023 COOLDOWN:
- doorcode = 0.
- Counter decrements by 1 per frame_tick and saturates at 0.
- Return to ARMED when counter == 0 and no unqualified hit (any of the four bands) is present on a frame_tick.
REQ-024 Position or room changes during ASSERT SHALL NOT alter doorcode.
REQ-025 doorcode and busy SHALL be registered outputs, with no combinational path from inputs.
REQ-026 Cooldown counter width SHALL be 8 bits; it never wraps below 0.

Reset
REQ-027 Reset low SHALL immediately force:
- state ARMED
- doorcode 0
- busy 0
- counter 0
- synchronizer flops 0
- latched code 0
REQ-028 Reset asserted mid-ASSERT or mid-COOLDOWN SHALL abort the event with no further doorcode output.
REQ-029 After release, the first frame_tick SHALL require a fresh vsync rising edge seen by both synchronizer flops.

Verification
REQ-030 Single door hit:
- Stimulus: room=0, x=635, y=240, one vsync rise.
- Response: doorcode=2 within 4 Clk, held until the next synchronized rise, then 0; busy high throughout.
REQ-031 Masked door:
- Stimulus: room=2, x=2, y=240, 3 frames.
- Response: doorcode stays 0 and busy stays 0.
REQ-032 Corner priority:
- Stimulus: room=5, x=3, y=3, with DOOR_LO=0.
- Response: doorcode=1 (left beats top).
REQ-033 Cooldown hold:
- Stimulus: after an event, player held at x=635, y=240 for 20 frames.
- Response: no second event; ARMED only after the player moves to x=320, and no earlier than 8 frames after ASSERT ends.
REQ-034 Reset mid-ASSERT:
- Stimulus: Reset low for 1 Clk while doorcode=3.
- Response: doorcode=0 and busy=0 asynchronously; re-arms on the next qualified hit.
REQ-035 Band edges:
- Stimulus: x=8 then x=9, y=200 then y=199, room=1.
- Response: hit at x=8, y=200; no hit at x=9 or at y=199.

Source files
------------

// File: rtl/door_detector.sv
// Door hit detector: samples player position on each synchronized vsync rise,
// reports a masked, prioritized door code for one frame, then holds off re-arming.
module door_detector #(
  parameter int DOOR_MARGIN     = 8,
  parameter int DOOR_LO         = 200,
  parameter int DOOR_HI         = 280,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [2:0] room,
  output logic [2:0] doorcode,
  output logic       busy
);

  localparam logic [9:0] MARGIN_C = 10'(DOOR_MARGIN);
  localparam logic [9:0] RIGHT_C  = 10'(639 - DOOR_MARGIN);
  localparam logic [9:0] BOTTOM_C = 10'(479 - DOOR_MARGIN);
  localparam logic [9:0] LO_C     = 10'(DOOR_LO);
  localparam logic [9:0] HI_C     = 10'(DOOR_HI);
  localparam logic [7:0] CD_INIT  = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // Door mask per room, bit order {bottom, top, right, left}.
  function automatic logic [3:0] door_mask(input logic [2:0] rm);
    logic [3:0] m;
    case (rm)
      3'd0:    m = 4'b0110;
      3'd1:    m = 4'b0011;
      3'd2:    m = 4'b1000;
      3'd3:    m = 4'b1001;
      3'd4:    m = 4'b0110;
      3'd5:    m = 4'b0111;
      3'd6:    m = 4'b1000;
      3'd7:    m = 4'b0001;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  logic       vs_meta_r, vs_sync_r, vs_prev_r;
  logic [2:0] warm_r;
  logic       frame_tick_s;
  logic       y_span_s, x_span_s;
  logic [3:0] hit_s, qual_s;
  logic [2:0] qual_code_s;
  state_t     state_r, state_nxt_s;
  logic [2:0] code_r, code_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [2:0] doorcode_r, doorcode_nxt_s;
  logic       busy_r, busy_nxt_s;

  // vsync synchronizer; warm_r blocks ticks until the edge detector holds genuinely sampled values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vs_meta_r <= 1'b0;
      vs_sync_r <= 1'b0;
      vs_prev_r <= 1'b0;
      warm_r    <= 3'b000;
    end else begin
      vs_meta_r <= vsync;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
      warm_r    <= {warm_r[1:0], 1'b1};
    end
  end

  assign frame_tick_s = vs_sync_r & ~vs_prev_r & warm_r[2];

  assign y_span_s = (player_y >= LO_C) && (player_y <= HI_C);
  assign x_span_s = (player_x >= LO_C) && (player_x <= HI_C);
  assign hit_s[0] = (player_x <= MARGIN_C) && y_span_s;
  assign hit_s[1] = (player_x >= RIGHT_C)  && y_span_s;
  assign hit_s[2] = (player_y <= MARGIN_C) && x_span_s;
  assign hit_s[3] = (player_y >= BOTTOM_C) && x_span_s;
  assign qual_s   = hit_s & door_mask(room);

  // Priority encoder: left > right > top > bottom.
  always_comb begin
    qual_code_s = 3'd0;
    if (qual_s[0])      qual_code_s = 3'd1;
    else if (qual_s[1]) qual_code_s = 3'd2;
    else if (qual_s[2]) qual_code_s = 3'd3;
    else if (qual_s[3]) qual_code_s = 3'd4;
    else                qual_code_s = 3'd0;
  end

  // State, latched code, cooldown counter and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_ARMED;
      code_r     <= 3'd0;
      cnt_r      <= 8'd0;
      doorcode_r <= 3'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      code_r     <= code_nxt_s;
      cnt_r      <= cnt_nxt_s;
      doorcode_r <= doorcode_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Next-state logic; all decisions happen only on a frame tick.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_ARMED: begin
        if (frame_tick_s && (qual_code_s != 3'd0)) begin
          state_nxt_s = ST_ASSERT;
          code_nxt_s  = qual_code_s;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_ASSERT: begin
        if (frame_tick_s) begin
          state_nxt_s = ST_COOLDOWN;
          cnt_nxt_s   = CD_INIT;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_COOLDOWN: begin
        if (frame_tick_s) begin
          if ((cnt_r == 8'd0) && (hit_s == 4'b0000)) begin
            state_nxt_s = ST_ARMED;
          end else if (cnt_r != 8'd0) begin
            cnt_nxt_s = cnt_r - 8'd1;
          end else begin
            cnt_nxt_s = 8'd0;
          end
        end else begin
          state_nxt_s = ST_COOLDOWN;
        end
      end
      default: begin
        state_nxt_s = ST_ARMED;
        code_nxt_s  = 3'd0;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Outputs derived from the next state so they are registered together with it.
  always_comb begin
    doorcode_nxt_s = 3'd0;
    busy_nxt_s     = 1'b0;
    if (state_nxt_s == ST_ASSERT) begin
      doorcode_nxt_s = code_nxt_s;
    end else begin
      doorcode_nxt_s = 3'd0;
    end
    if (state_nxt_s != ST_ARMED) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  assign doorcode = doorcode_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_door_detector.sv
// Scoreboard bench for door_detector: a frame-level reference model predicts door
// events; a monitor pops and compares whenever doorcode presents a new event.
module tb_door_detector;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vsync;
  logic [9:0] px, py;
  logic [2:0] room;
  logic [2:0] doorcode, doorcode_lo;
  logic       busy, busy_lo;

  always #5 Clk = ~Clk;

  door_detector u_dut (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .player_x(px), .player_y(py),
    .room(room), .doorcode(doorcode), .busy(busy)
  );

  door_detector #(.DOOR_LO(0)) u_dut_lo (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .player_x(px), .player_y(py),
    .room(room), .doorcode(doorcode_lo), .busy(busy_lo)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  // Reference model: mode 0 idle/armed, 1 reporting, 2 holding off.
  int mode = 0;
  int m_code = 0;
  int m_cnt = 0;

  function automatic int ref_code(int x, int y, int rm, int lo);
    logic [7:0] ml, mr, mt, mb;
    bit l, r, t, b;
    ml = 8'b1010_1010; mr = 8'b0011_0011; mt = 8'b0011_0001; mb = 8'b0100_1100;
    l = (x <= 8)   && (y >= lo) && (y <= 280) && ml[rm];
    r = (x >= 631) && (y >= lo) && (y <= 280) && mr[rm];
    t = (y <= 8)   && (x >= lo) && (x <= 280) && mt[rm];
    b = (y >= 471) && (x >= lo) && (x <= 280) && mb[rm];
    if (l) return 1;
    if (r) return 2;
    if (t) return 3;
    if (b) return 4;
    return 0;
  endfunction

  function automatic bit any_band(int x, int y);
    bit ys, xs;
    ys = (y >= 200) && (y <= 280);
    xs = (x >= 200) && (x <= 280);
    return ((x <= 8) && ys) || ((x >= 631) && ys) || ((y <= 8) && xs) || ((y >= 471) && xs);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; m_code = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input int x, input int y, input int rm);
    int c;
    c = ref_code(x, y, rm, 200);
    if (mode == 0) begin
      if (c != 0) begin
        mode = 1; m_code = c;
        exp_q.push_back(c);
      end
    end else if (mode == 1) begin
      mode = 2; m_cnt = 8;
    end else begin
      if (m_cnt == 0 && !any_band(x, y)) mode = 0;
      else if (m_cnt > 0) m_cnt--;
    end
  endtask

  task automatic frame(input int x, input int y, input int rm);
    @(negedge Clk);
    px = 10'(x); py = 10'(y); room = 3'(rm);
    repeat (3) @(negedge Clk);
    vsync = 1'b1;
    model_frame(x, y, rm);
    repeat (8) @(negedge Clk);
    vsync = 1'b0;
    repeat (6) @(negedge Clk);
    check("frame_doorcode", int'(doorcode), (mode == 1) ? m_code : 0);
    check("frame_busy", int'(busy), (mode != 0) ? 1 : 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 15 && mode != 0; i++) frame(320, 240, 0);
    check("drain_rearmed", mode, 0);
  endtask

  function automatic int pick(int hi_edge);
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 12);
      1:       return $urandom_range(hi_edge - 12, hi_edge);
      2:       return $urandom_range(190, 290);
      default: return $urandom_range(0, hi_edge);
    endcase
  endfunction

  // Monitor: every transition of doorcode away from 0 is one reported event.
  initial begin
    logic [2:0] prev_code;
    int e;
    prev_code = 3'd0;
    forever begin
      @(negedge Clk);
      if (doorcode != prev_code) begin
        if (prev_code == 3'd0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%0d expected=none at %0t", doorcode, $time);
          end else begin
            e = exp_q.pop_front();
            if (int'(doorcode) != e) begin
              failures++;
              $display("FAIL event_code actual=%0d expected=%0d at %0t", doorcode, e, $time);
            end
          end
        end else if (doorcode != 3'd0) begin
          checks++;
          failures++;
          $display("FAIL code_changed actual=%0d expected=%0d at %0t", doorcode, prev_code, $time);
        end
      end
      prev_code = doorcode;
    end
  end

  initial begin
    Reset = 1'b0; vsync = 1'b0; px = 10'd320; py = 10'd240; room = 3'd0;
    repeat (4) @(negedge Clk);
    check("reset_doorcode", int'(doorcode), 0);
    check("reset_busy", int'(busy), 0);
    Reset = 1'b1;

    // Corner: with DOOR_LO=0 left beats top; default instance sees no hit.
    frame(3, 3, 5);
    check("corner_priority_lo0", int'(doorcode_lo), 1);

    // Single right door, then held in the band: no second event.
    frame(635, 240, 0);
    for (int i = 0; i < 20; i++) frame(635, 240, 0);
    check("hold_still_busy", int'(busy), 1);
    drain();

    // Masked door in room 2.
    for (int i = 0; i < 3; i++) frame(2, 240, 2);

    // Band edges in room 1.
    frame(8, 240, 1);
    drain();
    frame(9, 240, 1);
    frame(4, 200, 1);
    drain();
    frame(4, 199, 1);

    // Reset released with vsync already high must not produce a tick.
    @(negedge Clk);
    Reset = 1'b0; vsync = 1'b1; px = 10'd635; py = 10'd240; room = 3'd0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    check("no_tick_after_reset", int'(doorcode), 0);
    check("no_busy_after_reset", int'(busy), 0);
    vsync = 1'b0;
    repeat (4) @(negedge Clk);
    frame(635, 240, 0);
    drain();

    // Reset mid-report of the top door, then re-arm.
    frame(240, 3, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("async_reset_doorcode", int'(doorcode), 0);
    check("async_reset_busy", int'(busy), 0);
    model_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    frame(240, 3, 0);
    drain();

    // Randomized frames.
    for (int i = 0; i < 250; i++) frame(pick(639), pick(479), $urandom_range(0, 7));

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
